// File: rtl/demux4_fifo.sv
// ============================================================================
// demux4_fifo : one 16-bit producer stream routed to four buffered channels
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux4_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [1:0]               s,
  output logic [WIDTH-1:0]         out1,
  output logic [WIDTH-1:0]         out2,
  output logic [WIDTH-1:0]         out3,
  output logic [WIDTH-1:0]         out4,
  output logic [3:0]               out_valid,
  input  logic [3:0]               out_ready,
  output logic [$clog2(DEPTH):0]   count1,
  output logic [$clog2(DEPTH):0]   count2,
  output logic [$clog2(DEPTH):0]   count3,
  output logic [$clog2(DEPTH):0]   count4
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [3:0]         w_full;
  logic [4*WIDTH-1:0] w_head_flat;
  logic [4*CW-1:0]    w_cnt_flat;

  // in_ready depends only on s and registered occupancy, never on out_ready.
  assign in_ready = ~w_full[s];

  generate
    for (genvar k = 0; k < 4; k++) begin : g_ch
      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [PW-1:0]    r_wptr;
      logic [PW-1:0]    r_rptr;
      logic [CW-1:0]    r_cnt;
      logic             w_push;
      logic             w_pop;

      assign w_push = in_valid && !w_full[s] && (s == 2'(k));
      assign w_pop  = (r_cnt != '0) && out_ready[k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
          end
          r_wptr <= '0;
          r_rptr <= '0;
          r_cnt  <= '0;
        end else begin
          if (w_push) begin
            r_mem[r_wptr] <= in_data;
            r_wptr        <= r_wptr + 1'b1;
          end
          if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
          end
          if (w_push && !w_pop) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (w_pop && !w_push) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      end

      assign w_full[k]                     = (r_cnt == C_FULL);
      assign out_valid[k]                  = (r_cnt != '0);
      assign w_head_flat[k*WIDTH +: WIDTH] = r_mem[r_rptr];
      assign w_cnt_flat[k*CW +: CW]        = r_cnt;
    end
  endgenerate

  assign out1   = w_head_flat[0*WIDTH +: WIDTH];
  assign out2   = w_head_flat[1*WIDTH +: WIDTH];
  assign out3   = w_head_flat[2*WIDTH +: WIDTH];
  assign out4   = w_head_flat[3*WIDTH +: WIDTH];
  assign count1 = w_cnt_flat[0*CW +: CW];
  assign count2 = w_cnt_flat[1*CW +: CW];
  assign count3 = w_cnt_flat[2*CW +: CW];
  assign count4 = w_cnt_flat[3*CW +: CW];

endmodule

`default_nettype wire
